// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types, defaults and address check for the DM arbiter
//   Contents: FSM state encoding, latched-request struct, MEM_WORDS default,
//   addr_err() misalignment / range check.
package dm_arb_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // One in-flight request, captured at accept.
  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        err;
  } req_t;

  // Word accesses only; legal byte addresses are 0 .. 4*mem_words-1.
  // Compared at 34 bits so a large mem_words cannot wrap the limit.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= ({2'b00, mem_words} << 2));
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - request, response and DM-side signals of the DM arbiter
//   p0_*/p1_*  : valid/ready request channels (we, addr, wdata, pc)
//   rsp_*      : one-hot response pulse with load data and error flag
//   mem_*      : drive to the data memory, mem_result returned from it
//   slave  : the arbiter
//   master : its environment (both requesters and the DM)
interface dm_arbiter_if;
  logic        p0_valid;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [31:0] p0_pc;
  logic        p0_ready;

  logic        p1_valid;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [31:0] p1_pc;
  logic        p1_ready;

  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_we;
  logic [31:0] mem_add;
  logic [31:0] mem_data;
  logic [31:0] mem_pc;
  logic [31:0] mem_result;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata, p0_pc,
    input  p1_valid, p1_we, p1_addr, p1_wdata, p1_pc,
    input  mem_result,
    output p0_ready, p1_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_add, mem_data, mem_pc
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p0_pc,
    output p1_valid, p1_we, p1_addr, p1_wdata, p1_pc,
    output mem_result,
    input  p0_ready, p1_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_add, mem_data, mem_pc
  );
endinterface

// File: rtl/dm_arbiter_rr.sv
// rtl/dm_arbiter_rr.sv - two-way round-robin arbiter owning the priority pointer
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request per port
//   advance   : a grant is being taken this cycle; move the pointer
//   gnt[1:0]  : one-hot grant (zero when nothing requests)
module rr_arbiter2 #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio;

  // A lone requester always wins; prio only decides a conflict.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other port gets priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= RESET_PRIO;
    end else if (advance && (gnt != 2'b00)) begin
      prio <= ~gnt[1];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin sharing of the single-port data memory by two requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : dm_arbiter_if.slave (p0/p1 requests, rsp_* response, mem_* to the DM)
//   One transaction in flight: IDLE (accept) -> ACCESS (DM cycle) -> RESP (pulse).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter bit          RESET_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   bus
);

  state_t      state, state_nxt;
  req_t        lat;
  req_t        acc;
  logic [31:0] rdata_q;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        accept;

  // Requests are only visible to the arbiter in IDLE and outside reset, so
  // ready can never rise in ACCESS/RESP or during the reset cycle.
  assign req    = ((state == ST_IDLE) && !rst) ? {bus.p1_valid, bus.p0_valid} : 2'b00;
  assign accept = |gnt;

  rr_arbiter2 #(.RESET_PRIO(RESET_PRIO)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  // Fields of the granted port, with the error decided at accept time.
  always_comb begin
    acc.port  = gnt[1];
    acc.we    = gnt[1] ? bus.p1_we    : bus.p0_we;
    acc.addr  = gnt[1] ? bus.p1_addr  : bus.p0_addr;
    acc.wdata = gnt[1] ? bus.p1_wdata : bus.p0_wdata;
    acc.pc    = gnt[1] ? bus.p1_pc    : bus.p0_pc;
    acc.err   = addr_err(acc.addr, MEM_WORDS);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and response data register
  always_ff @(posedge clk) begin
    if (rst) begin
      lat     <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        lat <= acc;
      end
      if (state == ST_ACCESS) begin
        rdata_q <= (lat.we || lat.err) ? 32'd0 : bus.mem_result;
      end
    end
  end

  // Outputs; everything is forced low in the reset cycle so an ACCESS
  // interrupted by rst never writes the DM.
  always_comb begin
    bus.p0_ready  = 1'b0;
    bus.p1_ready  = 1'b0;
    bus.rsp_valid = 2'b00;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.mem_we    = 1'b0;
    bus.mem_add   = 32'd0;
    bus.mem_data  = 32'd0;
    bus.mem_pc    = 32'd0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          bus.p0_ready = gnt[0];
          bus.p1_ready = gnt[1];
        end
        ST_ACCESS: begin
          bus.mem_we   = lat.we & ~lat.err;
          bus.mem_add  = lat.addr;
          bus.mem_data = lat.wdata;
          bus.mem_pc   = lat.pc;
        end
        ST_RESP: begin
          bus.rsp_valid = lat.port ? 2'b10 : 2'b01;
          bus.rsp_err   = lat.err;
          bus.rsp_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] tb_mem [1024];
  int we_cnt   = 0;
  int rsp_cnt  = 0;
  int rsp1_cnt = 0;

  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.MEM_WORDS(1024), .RESET_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory model: combinational read, write on posedge.
  assign bus.mem_result = tb_mem[bus.mem_add[11:2]];
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_add[11:2]] <= bus.mem_data;
  end

  always @(negedge clk) begin
    if (bus.mem_we) we_cnt++;
    if (bus.rsp_valid != 2'b00) rsp_cnt++;
    if (bus.rsp_valid[1]) rsp1_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    if (port == 0) begin
      bus.p0_valid = v; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_pc = pc;
    end else begin
      bus.p1_valid = v; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_pc = pc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    step();
    step();
    drive(0, 1'b1, 1'b1, 32'h10, 32'h1, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h14, 32'h2, 32'h0);
    #1;
    n_checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {bus.p1_ready, bus.p0_ready}); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    n_checks++; if ({bus.rsp_err, bus.rsp_rdata} !== 33'd0) begin n_fail++; $display("FAIL reset_rsp: got err=%b rdata=%h expected 0/0", bus.rsp_err, bus.rsp_rdata); end
    n_checks++; if ({bus.mem_we, bus.mem_add, bus.mem_data, bus.mem_pc} !== 97'd0) begin n_fail++; $display("FAIL reset_mem: got we=%b add=%h expected all 0", bus.mem_we, bus.mem_add); end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h100);
    #1;
    n_checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b01) begin n_fail++; $display("FAIL st_ready: got %b expected 01", {bus.p1_ready, bus.p0_ready}); end
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if ({bus.mem_we, bus.mem_add, bus.mem_data, bus.mem_pc} !== {1'b1, 32'h10, 32'hDEADBEEF, 32'h100}) begin n_fail++; $display("FAIL st_mem: got we=%b add=%h data=%h pc=%h expected 1/10/deadbeef/100", bus.mem_we, bus.mem_add, bus.mem_data, bus.mem_pc); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL st_early_rsp: got %b expected 00", bus.rsp_valid); end
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.mem_we} !== 4'b0100) begin n_fail++; $display("FAIL st_rsp: got valid=%b err=%b we=%b expected 01/0/0", bus.rsp_valid, bus.rsp_err, bus.mem_we); end
    n_checks++; if (tb_mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_dm: got %h expected deadbeef", tb_mem[4]); end
    step();
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 32'h104);
    #1;
    n_checks++; if (bus.p0_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready: got %b expected 1", bus.p0_ready); end
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ld_we: got %b expected 0", bus.mem_we); end
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 32'hDEADBEEF}) begin n_fail++; $display("FAIL ld_rsp: got valid=%b rdata=%h expected 01/deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  task automatic test_round_robin();
    int grants[$];
    do_reset();
    tb_mem[16] = 32'h11110000;
    tb_mem[17] = 32'h22220001;
    drive(0, 1'b1, 1'b0, 32'h40, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h44, 32'd0, 32'd0);
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++; if (bus.p0_ready && bus.p1_ready) begin n_fail++; $display("FAIL rr_both_ready: cycle %0d got 11 expected at most one", c); end
      n_checks++; if (!$onehot0(bus.rsp_valid)) begin n_fail++; $display("FAIL rr_onehot: cycle %0d got %b expected one-hot", c, bus.rsp_valid); end
      if (bus.rsp_valid == 2'b01) begin
        n_checks++; if (bus.rsp_rdata !== 32'h11110000) begin n_fail++; $display("FAIL rr_rdata0: got %h expected 11110000", bus.rsp_rdata); end
      end
      if (bus.rsp_valid == 2'b10) begin
        n_checks++; if (bus.rsp_rdata !== 32'h22220001) begin n_fail++; $display("FAIL rr_rdata1: got %h expected 22220001", bus.rsp_rdata); end
      end
      if (bus.p0_ready) grants.push_back(0);
      if (bus.p1_ready) grants.push_back(1);
      step();
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    n_checks++; if (grants.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 4", grants.size()); end
    for (int g = 0; g < grants.size() && g < 4; g++) begin
      n_checks++; if (grants[g] != (g % 2)) begin n_fail++; $display("FAIL rr_order: grant %0d got port %0d expected %0d", g, grants[g], g % 2); end
    end
    step();
    step();
  endtask

  task automatic test_errors();
    int we0;
    we0 = we_cnt;
    drive(1, 1'b1, 1'b0, 32'h13, 32'd0, 32'd0);
    #1;
    n_checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b10) begin n_fail++; $display("FAIL err_mis_ready: got %b expected 10", {bus.p1_ready, bus.p0_ready}); end
    step();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 1'b1, 32'd0}) begin n_fail++; $display("FAIL err_mis_rsp: got valid=%b err=%b rdata=%h expected 10/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    step();
    drive(1, 1'b1, 1'b1, 32'h1000, 32'h12345678, 32'd0);
    #1;
    step();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL err_oor_we: got %b expected 0", bus.mem_we); end
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_err} !== 3'b101) begin n_fail++; $display("FAIL err_oor_rsp: got valid=%b err=%b expected 10/1", bus.rsp_valid, bus.rsp_err); end
    step();
    n_checks++; if (we_cnt != we0) begin n_fail++; $display("FAIL err_we_count: got %0d writes expected %0d", we_cnt, we0); end
    n_checks++; if (tb_mem[0] !== 32'd0) begin n_fail++; $display("FAIL err_dm: got %h expected 0", tb_mem[0]); end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = rsp_cnt;
    drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h200);
    #1;
    n_checks++; if (bus.p0_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b expected 1", bus.p0_ready); end
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.mem_we, bus.mem_add} !== 33'd0) begin n_fail++; $display("FAIL rm_mem: got we=%b add=%h expected 0/0", bus.mem_we, bus.mem_add); end
    step();
    rst = 1'b0;
    step();
    step();
    n_checks++; if (rsp_cnt != r0) begin n_fail++; $display("FAIL rm_no_rsp: got %0d responses expected %0d", rsp_cnt, r0); end
    n_checks++; if (tb_mem[8] !== 32'd0) begin n_fail++; $display("FAIL rm_dm: got %h expected 0", tb_mem[8]); end
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h24, 32'd0, 32'd0);
    #1;
    n_checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b01) begin n_fail++; $display("FAIL rm_prio: got %b expected 01", {bus.p1_ready, bus.p0_ready}); end
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b01, 32'd0}) begin n_fail++; $display("FAIL rm_load: got valid=%b rdata=%h expected 01/0", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [8:0] rdy_mask;
    logic [8:0] rsp_mask;
    rdy_mask = '0;
    rsp_mask = '0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 32'd0);
    for (int c = 0; c < 9; c++) begin
      if (c == 8) drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      #1;
      rdy_mask[c] = bus.p0_ready;
      rsp_mask[c] = bus.rsp_valid[0];
      step();
    end
    n_checks++; if (rdy_mask !== 9'h049) begin n_fail++; $display("FAIL b2b_ready: got %b expected 001001001", rdy_mask); end
    n_checks++; if (rsp_mask !== 9'h124) begin n_fail++; $display("FAIL b2b_rsp: got %b expected 100100100", rsp_mask); end
  endtask

  task automatic test_drop_valid();
    int r1;
    r1 = rsp1_cnt;
    drive(0, 1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 32'h300);
    #1;
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h30, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.p1_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b expected 0", bus.p1_ready); end
    step();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL drop_p0_rsp: got %b expected 01", bus.rsp_valid); end
    step();
    step();
    step();
    step();
    n_checks++; if (rsp1_cnt != r1) begin n_fail++; $display("FAIL drop_p1_rsp: got %0d p1 responses expected %0d", rsp1_cnt, r1); end
    n_checks++; if (tb_mem[12] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL drop_dm: got %h expected 5a5a5a5a", tb_mem[12]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'd0;
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_round_robin();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_drop_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
